nco_i2c_master: RTL and testbench

- Write-only I2C master. It is the initiating end of the SDR-3 NCO/control I2C link, driving the FPGA's nco_scl/nco_sda slave.
- Serialises a register address and a 32-bit payload (NCO frequency word or control word) to a 7-bit slave address.
- Drives open-drain enables with clock-stretch support.
- Used by the SDR-3 host-side controller logic and as the bus driver in the core's integration bench.

---
 rtl/nco_i2c_master.sv | 215 +++++++++++++++++++++
 tb/tb_nco_i2c_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_i2c_master.sv
// Write-only I2C master: START, {SLAVE_ADDR,W}, register address, DATA_BYTES payload
// bytes MSB-first, STOP. Open-drain enables, with slave clock stretching honoured.
module nco_i2c_master #(
    parameter int unsigned CLK_DIV    = 184,
    parameter logic [6:0]  SLAVE_ADDR = 7'h20,
    parameter int unsigned DATA_BYTES = 4
) (
    input  logic        AD9866clk,
    input  logic        extreset,
    input  logic        start,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        scl_i,
    input  logic        sda_i
);

    localparam logic [9:0] QEND      = 10'(CLK_DIV - 1);
    localparam logic [2:0] LAST_BYTE = 3'(DATA_BYTES + 1);
    localparam int         TOP_BIT   = 8 * DATA_BYTES - 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t      state_r, state_n;
    logic [1:0]  quarter_r, quarter_n;
    logic [9:0]  qcnt_r, qcnt_n;
    logic [2:0]  bit_cnt_r, bit_cnt_n;
    logic [2:0]  byte_cnt_r, byte_cnt_n;
    logic [7:0]  shift_r, shift_n;
    logic [7:0]  reg_addr_r, reg_addr_n;
    logic [31:0] payload_r, payload_n;
    logic        ack_err_r, ack_err_n;
    logic        busy_r, done_r, scl_oe_r, sda_oe_r;
    logic        stretch_s, hold_s, tick_s;
    logic [1:0]  drive_s;

    // Line drive per state/quarter, encoded as {scl_oe, sda_oe}.
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q, input logic bit_v);
        logic [1:0] d;
        case (st)
            ST_START: begin
                case (q)
                    2'd0:    d = 2'b00;
                    2'd1:    d = 2'b01;
                    2'd2:    d = 2'b01;
                    default: d = 2'b11;
                endcase
            end
            ST_BIT:  d = {~q[1], ~bit_v};
            ST_ACK:  d = {~q[1], 1'b0};
            ST_STOP: begin
                case (q)
                    2'd0:    d = 2'b11;
                    2'd1:    d = 2'b01;
                    default: d = 2'b00;
                endcase
            end
            default: d = 2'b00;
        endcase
        return d;
    endfunction

    // Quarter timer, byte/bit sequencing and next-state selection.
    always_comb begin
        state_n    = state_r;
        quarter_n  = quarter_r;
        qcnt_n     = qcnt_r;
        bit_cnt_n  = bit_cnt_r;
        byte_cnt_n = byte_cnt_r;
        shift_n    = shift_r;
        reg_addr_n = reg_addr_r;
        payload_n  = payload_r;
        ack_err_n  = ack_err_r;

        // The timer is frozen at zero while a released SCL is still held low by the slave.
        stretch_s = (((state_r == ST_BIT) || (state_r == ST_ACK)) && (quarter_r == 2'd2)) ||
                    ((state_r == ST_STOP) && (quarter_r == 2'd1));
        hold_s    = stretch_s && !scl_i;
        tick_s    = (qcnt_r == QEND) && !hold_s;

        if ((state_r == ST_IDLE) || (state_r == ST_DONE) || hold_s || tick_s) begin
            qcnt_n = 10'd0;
        end else begin
            qcnt_n = qcnt_r + 10'd1;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n    = ST_START;
                    quarter_n  = 2'd0;
                    shift_n    = {SLAVE_ADDR, 1'b0};
                    bit_cnt_n  = 3'd7;
                    byte_cnt_n = 3'd0;
                    reg_addr_n = reg_addr;
                    payload_n  = wr_data;
                    ack_err_n  = 1'b0;
                end else begin
                    quarter_n = 2'd0;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    quarter_n = quarter_r + 2'd1;
                    state_n   = (quarter_r == 2'd3) ? ST_BIT : ST_START;
                end else begin
                    quarter_n = quarter_r;
                end
            end
            ST_BIT: begin
                if (tick_s && (quarter_r == 2'd3)) begin
                    quarter_n = 2'd0;
                    if (bit_cnt_r == 3'd0) begin
                        state_n = ST_ACK;
                    end else begin
                        bit_cnt_n = bit_cnt_r - 3'd1;
                        shift_n   = {shift_r[6:0], 1'b0};
                    end
                end else if (tick_s) begin
                    quarter_n = quarter_r + 2'd1;
                end else begin
                    quarter_n = quarter_r;
                end
            end
            ST_ACK: begin
                if (tick_s && (quarter_r == 2'd3)) begin
                    quarter_n = 2'd0;
                    if (sda_i) begin
                        ack_err_n = 1'b1;
                        state_n   = ST_STOP;
                    end else if (byte_cnt_r == LAST_BYTE) begin
                        state_n = ST_STOP;
                    end else begin
                        state_n    = ST_BIT;
                        byte_cnt_n = byte_cnt_r + 3'd1;
                        bit_cnt_n  = 3'd7;
                        if (byte_cnt_r == 3'd0) begin
                            shift_n = reg_addr_r;
                        end else begin
                            shift_n   = payload_r[TOP_BIT -: 8];
                            payload_n = {payload_r[23:0], 8'h00};
                        end
                    end
                end else if (tick_s) begin
                    quarter_n = quarter_r + 2'd1;
                end else begin
                    quarter_n = quarter_r;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    quarter_n = quarter_r + 2'd1;
                    state_n   = (quarter_r == 2'd3) ? ST_DONE : ST_STOP;
                end else begin
                    quarter_n = quarter_r;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        drive_s = bus_drive(state_n, quarter_n, shift_n[7]);
    end

    // State and registered outputs; reset releases both lines immediately.
    always_ff @(posedge AD9866clk or negedge extreset) begin
        if (!extreset) begin
            state_r    <= ST_IDLE;
            quarter_r  <= 2'd0;
            qcnt_r     <= 10'd0;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= 3'd0;
            shift_r    <= 8'h00;
            reg_addr_r <= 8'h00;
            payload_r  <= 32'h0000_0000;
            ack_err_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            scl_oe_r   <= 1'b0;
            sda_oe_r   <= 1'b0;
        end else begin
            state_r    <= state_n;
            quarter_r  <= quarter_n;
            qcnt_r     <= qcnt_n;
            bit_cnt_r  <= bit_cnt_n;
            byte_cnt_r <= byte_cnt_n;
            shift_r    <= shift_n;
            reg_addr_r <= reg_addr_n;
            payload_r  <= payload_n;
            ack_err_r  <= ack_err_n;
            busy_r     <= (state_n != ST_IDLE) && (state_n != ST_DONE);
            done_r     <= (state_n == ST_DONE);
            scl_oe_r   <= drive_s[1];
            sda_oe_r   <= drive_s[0];
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign ack_err = ack_err_r;
    assign scl_oe  = scl_oe_r;
    assign sda_oe  = sda_oe_r;

endmodule

// File: tb/tb_nco_i2c_master.sv
// Directed bench for nco_i2c_master: bus-level slave model/decoder with ACK, NACK and
// clock-stretch injection, plus latency, busy/done and mid-transfer reset checks.
module tb_nco_i2c_master;

    localparam int CLK_DIV = 4;
    localparam int DB      = 4;

    logic        clk = 1'b0;
    logic        extreset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  reg_addr = 8'h00;
    logic [31:0] wr_data = 32'h0;
    logic        busy, done, ack_err, scl_oe, sda_oe;
    logic        scl_i, sda_i;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Slave model state (owned by the slave_model process).
    logic       scl_hold = 1'b0;
    logic       ack_pull = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic [8:0] shreg = 9'h0;
    logic [7:0] bus_byte [16];
    logic       bus_ack [16];
    int bitcnt = 0, nbytes = 0, hold_cnt = 0, hi_cnt = 0, stretch_hi = 0;
    int starts = 0, stops = 0, rises = 0, done_cnt = 0;

    // Knobs set by the stimulus process.
    int   nack_idx = 99;
    logic stretch_en = 1'b0;

    // Snapshots taken before each transaction.
    int s0, p0, r0, d0;

    nco_i2c_master #(
        .CLK_DIV(CLK_DIV),
        .SLAVE_ADDR(7'h20),
        .DATA_BYTES(DB)
    ) dut (
        .AD9866clk(clk),
        .extreset(extreset),
        .start(start),
        .reg_addr(reg_addr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .ack_err(ack_err),
        .scl_oe(scl_oe),
        .sda_oe(sda_oe),
        .scl_i(scl_i),
        .sda_i(sda_i)
    );

    assign scl_i = ~scl_oe & ~scl_hold;
    assign sda_i = ~sda_oe & ~ack_pull;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Open-drain bus: decode START/STOP/bytes, ACK where asked, stretch one chosen bit.
    initial begin : slave_model
        logic cs, cd;
        forever begin
            @(negedge clk);
            if (scl_hold && !scl_oe) begin
                hold_cnt = hold_cnt + 1;
                if (hold_cnt == 51) scl_hold = 1'b0;
            end
            cs = ~scl_oe & ~scl_hold;
            cd = ~sda_oe & ~ack_pull;
            if (done) done_cnt = done_cnt + 1;
            if (cs) hi_cnt = hi_cnt + 1;
            if (prev_scl && cs && prev_sda && !cd) begin
                starts = starts + 1;
                bitcnt = 0;
                nbytes = 0;
                ack_pull = 1'b0;
            end else if (prev_scl && cs && !prev_sda && cd) begin
                stops = stops + 1;
                bitcnt = 0;
                ack_pull = 1'b0;
            end else if (!prev_scl && cs) begin
                rises = rises + 1;
                shreg = {shreg[7:0], cd};
                bitcnt = bitcnt + 1;
                if (bitcnt == 9) begin
                    if (nbytes < 16) begin
                        bus_byte[nbytes] = shreg[8:1];
                        bus_ack[nbytes]  = shreg[0];
                    end
                    nbytes = nbytes + 1;
                    bitcnt = 0;
                end
            end else if (prev_scl && !cs) begin
                if (nbytes == 1 && bitcnt == 5) stretch_hi = hi_cnt;
                hi_cnt = 0;
                if (bitcnt == 8 && nbytes != nack_idx) ack_pull = 1'b1;
                else if (bitcnt == 0) ack_pull = 1'b0;
                if (stretch_en && nbytes == 1 && bitcnt == 4) begin
                    scl_hold = 1'b1;
                    hold_cnt = 0;
                end
            end
            prev_scl = cs;
            prev_sda = cd;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s0 = starts;
        p0 = stops;
        r0 = rises;
        d0 = done_cnt;
    endtask

    // Issue one transaction and wait (bounded) for done; optional second start while busy.
    task automatic run_txn(input logic [7:0] ra, input logic [31:0] wd, input int restart_at, output int lat);
        int t0;
        lat = -1;
        @(negedge clk);
        reg_addr = ra;
        wr_data  = wd;
        start    = 1'b1;
        t0       = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 3000; i++) begin
            if (i == restart_at) begin
                check_eq("busy_at_restart", 32'(busy), 32'd1);
                start    = 1'b1;
                reg_addr = 8'hEE;
                wr_data  = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Compare the decoded bus traffic and handshake against the expected transaction.
    task automatic verify(input string tag, input logic [7:0] ra, input logic [31:0] wd, input int nack_at,
                          input int n_exp, input int lat, input int lat_exp);
        logic [7:0] eb;
        check_eq({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_eq({tag, "_ack_err"}, 32'(ack_err), (nack_at < n_exp) ? 32'd1 : 32'd0);
        repeat (20) @(negedge clk);
        check_eq({tag, "_ack_err_hold"}, 32'(ack_err), (nack_at < n_exp) ? 32'd1 : 32'd0);
        check_eq({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check_eq({tag, "_starts"}, 32'(starts - s0), 32'd1);
        check_eq({tag, "_stops"}, 32'(stops - p0), 32'd1);
        check_eq({tag, "_scl_pulses"}, 32'(rises - r0), 32'(9 * n_exp + 1));
        check_eq({tag, "_nbytes"}, 32'(nbytes), 32'(n_exp));
        for (int k = 0; k < n_exp && k < 16; k++) begin
            if (k == 0) eb = 8'h40;
            else if (k == 1) eb = ra;
            else eb = wd[31 - 8 * (k - 2) -: 8];
            check_eq($sformatf("%s_byte%0d", tag, k), 32'({bus_ack[k], bus_byte[k]}),
                     32'({(k == nack_at) ? 1'b1 : 1'b0, eb}));
        end
    endtask

    initial begin : stimulus
        int lat;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", 32'({scl_oe, sda_oe, busy, done, ack_err}), 32'd0);
        extreset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_outputs", 32'({scl_oe, sda_oe, busy, done, ack_err}), 32'd0);

        // Full write, all bytes ACKed.
        snap();
        run_txn(8'h01, 32'h0123_4567, 0, lat);
        verify("full", 8'h01, 32'h0123_4567, 99, 6, lat, 897);
        check_eq("full_scl_high", 32'(stretch_hi), 32'(2 * CLK_DIV));

        // Address NACK.
        nack_idx = 0;
        snap();
        run_txn(8'h01, 32'h0123_4567, 0, lat);
        verify("nack_addr", 8'h01, 32'h0123_4567, 0, 1, lat, 177);

        // Third payload byte NACKed.
        nack_idx = 4;
        snap();
        run_txn(8'h5A, 32'hA5C3_0F96, 0, lat);
        verify("nack_p2", 8'h5A, 32'hA5C3_0F96, 4, 5, lat, 753);
        nack_idx = 99;

        // Stretch of 50 cycles on reg_addr bit 3.
        stretch_en = 1'b1;
        snap();
        run_txn(8'h01, 32'h0123_4567, 0, lat);
        verify("stretch", 8'h01, 32'h0123_4567, 99, 6, lat, 947);
        check_eq("stretch_scl_high", 32'(stretch_hi), 32'(2 * CLK_DIV));
        stretch_en = 1'b0;

        // Second start while busy must be ignored.
        snap();
        run_txn(8'h3C, 32'h89AB_CDEF, 100, lat);
        verify("busy_start", 8'h3C, 32'h89AB_CDEF, 99, 6, lat, 897);

        // Reset in the middle of payload byte 2.
        snap();
        @(negedge clk);
        reg_addr = 8'h77;
        wr_data  = 32'h1122_3344;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (520) @(negedge clk);
        check_eq("reset_point_nbytes", 32'(nbytes), 32'd3);
        extreset = 1'b0;
        #1;
        check_eq("midreset_lines", 32'({scl_oe, sda_oe, busy}), 32'd0);
        repeat (20) @(negedge clk);
        check_eq("midreset_no_done", 32'(done_cnt - d0), 32'd0);
        extreset = 1'b1;
        repeat (5) @(negedge clk);
        snap();
        run_txn(8'h77, 32'h1122_3344, 0, lat);
        verify("after_reset", 8'h77, 32'h1122_3344, 99, 6, lat, 897);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
